sipo_deserializer: RTL and testbench



---
 rtl/sipo_deserializer.sv | 208 ++++++++++++++++++++
 tb/tb_sipo_deserializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in, parallel-out receiver.
// Collects WIDTH bits (one per bit_valid edge) into a shift register and hands
// the finished word to a one-word holding register with a valid/ready
// handshake, so shifting can continue while a word waits for the consumer.
// Optional feature macro: SIPO_PARITY_CHECK_EN. When defined, each word is
// followed by one even-parity bit and a parity_err output flags bad words.
// Reset is asynchronous and active-high.
module sipo_deserializer #(
  parameter int WIDTH     = 4,  // data bits per word, must be >= 2
  parameter bit LSB_FIRST = 1   // 1: first bit lands in dout[0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             sin,
  input  logic             abort,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
`ifdef SIPO_PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

  // Counter is wide enough to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
`ifdef SIPO_PARITY_CHECK_EN
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
`endif

  // Two-bit encoding so the parity build can add its extra state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  // Shift register contents after accepting sin this edge.
  logic [WIDTH-1:0] shift_in;
  // Word completion event and the word it delivers.
  logic             complete;
  logic [WIDTH-1:0] word_done;
  logic             word_perr;
  // Holding register handshake terms.
  logic             consume;
  logic             hold_free;

  // Per-bit shift network: right shift (new bit at MSB) for LSB-first,
  // left shift (new bit at LSB) for MSB-first.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (LSB_FIRST) begin : g_right
        if (gi == WIDTH - 1) begin : g_entry
          assign shift_in[gi] = sin;
        end else begin : g_pass
          assign shift_in[gi] = shift_q[gi+1];
        end
      end else begin : g_left
        if (gi == 0) begin : g_entry
          assign shift_in[gi] = sin;
        end else begin : g_pass
          assign shift_in[gi] = shift_q[gi-1];
        end
      end
    end
  endgenerate

  // Receive FSM: next state, bit counter, shift register and COMPLETE event.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    complete  = 1'b0;
    word_done = shift_q;
    word_perr = 1'b0;
    if (abort) begin
      // Abort outranks a bit arriving on the same edge.
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          shift_d = shift_in;
          cnt_d   = ONE_CNT;
          state_d = SHIFT;
        end
        SHIFT: begin
          shift_d = shift_in;
          if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_CHECK_EN
            // All data bits in; the next bit is the parity bit.
            cnt_d   = FULL_CNT;
            state_d = PARITY;
`else
            complete  = 1'b1;
            word_done = shift_in;
            cnt_d     = '0;
            state_d   = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          complete  = 1'b1;
          word_done = shift_q;
          word_perr = ^{shift_q, sin};
          cnt_d     = '0;
          state_d   = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end
      endcase
    end
  end

  // Holding register: load on COMPLETE when free, clear valid on consume,
  // flag a dropped word as a sticky overrun (set beats clear).
  always_comb begin
    consume      = dout_valid_q && dout_ready;
    hold_free    = !dout_valid_q || dout_ready;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    if (complete && hold_free) begin
      dout_d       = word_done;
      dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_d = word_perr;
`endif
    end else if (consume) begin
      dout_valid_d = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_d = 1'b0;
`endif
    end
    if (complete && !hold_free) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q == SHIFT);
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`endif

  // word_perr only feeds the parity build.
  logic unused_ok;
  assign unused_ok = word_perr;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (default build, WIDTH=4). Two instances, one
// LSB-first and one MSB-first, share the same stimulus; a queue-based model
// tracks the partial word, holding register and overrun flag.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_valid, sin, abort, dout_ready, clr_overrun;
  logic [W-1:0] dout_l, dout_m;
  logic         dv_l, dv_m, busy_l, busy_m, ov_l, ov_m;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit           q_bits[$];
  bit           m_valid;
  bit [W-1:0]   m_word_l, m_word_m;
  bit           m_ov;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .sin(sin), .abort(abort),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready), .busy(busy_l),
    .overrun(ov_l), .clr_overrun(clr_overrun));

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .sin(sin), .abort(abort),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready), .busy(busy_m),
    .overrun(ov_m), .clr_overrun(clr_overrun));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_valid  = 1'b0;
    m_word_l = '0;
    m_word_m = '0;
    m_ov     = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit bv, input bit s, input bit ab,
                            input bit rdy, input bit cl);
    bit         done = 1'b0;
    bit         free;
    bit [W-1:0] wl = '0;
    bit [W-1:0] wm = '0;
    if (ab) q_bits.delete();
    else if (bv) begin
      q_bits.push_back(s);
      if (q_bits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wl[i]       = q_bits[i];
          wm[W-1-i]   = q_bits[i];
        end
        q_bits.delete();
      end
    end
    free = !m_valid || rdy;
    if (done && free) begin
      m_valid  = 1'b1;
      m_word_l = wl;
      m_word_m = wm;
    end else if (m_valid && rdy) m_valid = 1'b0;
    if (done && !free) m_ov = 1'b1;
    else if (cl) m_ov = 1'b0;
  endtask

  task automatic compare_all();
    check("dout_lsb", 32'(dout_l), 32'(m_word_l));
    check("dout_msb", 32'(dout_m), 32'(m_word_m));
    check("valid_lsb", 32'(dv_l), 32'(m_valid));
    check("valid_msb", 32'(dv_m), 32'(m_valid));
    check("busy_lsb", 32'(busy_l), 32'(q_bits.size() != 0));
    check("busy_msb", 32'(busy_m), 32'(q_bits.size() != 0));
    check("ovr_lsb", 32'(ov_l), 32'(m_ov));
    check("ovr_msb", 32'(ov_m), 32'(m_ov));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare 1 ns later.
  task automatic step(input bit bv, input bit s, input bit ab, input bit rdy, input bit cl);
    bit_valid = bv; sin = s; abort = ab; dout_ready = rdy; clr_overrun = cl;
    @(posedge clk);
    model_edge(bv, s, ab, rdy, cl);
    #1;
    compare_all();
  endtask

  task automatic send_word(input bit [W-1:0] w, input bit rdy);
    for (int i = 0; i < W; i++) step(1'b1, w[i], 1'b0, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bit_valid = 0; sin = 0; abort = 0; dout_ready = 0; clr_overrun = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Stream 1,1,0,1: LSB-first gives 1011, MSB-first gives 1101.
    step(1, 1, 0, 1, 0); check("busy_b1", 32'(busy_l), 32'd1);
    step(1, 1, 0, 1, 0); check("busy_b2", 32'(busy_l), 32'd1);
    step(1, 0, 0, 1, 0); check("busy_b3", 32'(busy_l), 32'd1);
    step(1, 1, 0, 1, 0);
    check("word_lsb_1011", 32'(dout_l), 32'hB);
    check("word_msb_1101", 32'(dout_m), 32'hD);
    check("valid_after_4th", 32'(dv_l), 32'd1);
    check("busy_after_4th", 32'(busy_l), 32'd0);
    step(0, 0, 0, 1, 0);
    check("valid_one_cycle", 32'(dv_l), 32'd0);

    // Overrun: A pending, 5 arrives and is dropped; then clear.
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    check("ovr_keep_A", 32'(dout_l), 32'hA);
    check("ovr_set", 32'(ov_l), 32'd1);
    step(0, 0, 0, 0, 1);
    check("ovr_cleared", 32'(ov_l), 32'd0);

    // Consume on the same edge that 3 completes, A still pending.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    check("swap_dout_3", 32'(dout_l), 32'h3);
    check("swap_valid", 32'(dv_l), 32'd1);
    check("swap_no_ovr", 32'(ov_l), 32'd0);
    step(0, 0, 0, 1, 0);

    // Two bits, abort (with a bit on the same edge), then 0,1,1,0.
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    check("abort_idle", 32'(busy_l), 32'd0);
    send_word(4'b0110, 1'b1);
    check("after_abort_0110", 32'(dout_l), 32'h6);

    // Asynchronous reset mid-word: outputs clear before any clock edge.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_dout", 32'(dout_l), 32'd0);
    check("arst_valid", 32'(dv_l), 32'd0);
    check("arst_busy", 32'(busy_l), 32'd0);
    check("arst_ovr", 32'(ov_l), 32'd0);
    #1 reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4,
           $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
